instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer end of the op/funct interface: fetches 32-bit MIPS words from instruction memory and presents
//  decoded fields (op, funct, rs, rt, rd, shamt, imm) to the control unit and datapath.
//  Owns the PC. Runs a req/ack handshake with imem. Supports datapath stall and branch redirect.
//  Sits between instruction memory and control_unit/register file.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//  ADDR_W     32             width of PC / imem address
// PORTS
//  clk            in   1       single clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  imem_req       out  1       fetch request; held until imem_ack
//  imem_addr      out  ADDR_W  word-aligned fetch address (= PC); stable while imem_req=1
//  imem_ack       in   1       one-cycle pulse, imem_rdata valid same cycle; may arrive in same cycle as req
//  imem_rdata     in   32      instruction word
//  stall          in   1       datapath cannot accept current instruction
//  branch_taken   in   1       one-cycle redirect pulse
//  branch_target  in   ADDR_W  redirect address; bits [1:0] forced to 0 internally
//  instr_valid    out  1       instr/fields hold a live instruction
//  instr          out  32      registered instruction word (0 = NOP when instr_valid=0)
//  op             out  6       instr[31:26]
//  rs             out  5       instr[25:21]
//  rt             out  5       instr[20:16]
//  rd             out  5       instr[15:11]
//  shamt          out  5       instr[10:6]
//  funct          out  6       instr[5:0]
//  imm            out  16      instr[15:0]
//  pc_plus4       out  ADDR_W  address of issued instruction + 4 (for branch/jal calc)
// BEHAVIOUR
//  Reset (async, immediate): state=FETCH_IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   instr=0, pc_plus4=RESET_PC+4, discard=0. A pending ack during/after reset is ignored.
//  States: IDLE (1 cycle after reset deassert), FETCH, ISSUE.
//  - IDLE -> FETCH unconditionally; imem_req rises the first clock edge after reset deasserts.
//  - FETCH: imem_req=1, imem_addr=PC. On imem_ack: if discard=0, instr<=imem_rdata,
//    pc_plus4<=PC+4, instr_valid<=1, go ISSUE. If discard=1: clear discard, drop data, stay FETCH
//    (req stays 1 next cycle with new PC).
//  - ISSUE: imem_req=0, instr_valid=1, outputs held stable. If stall=0: PC<=PC+4, instr_valid<=0,
//    instr<=0, go FETCH. If stall=1: hold everything.
//  Branch: branch_taken=1 in any non-reset state -> PC<={branch_target[ADDR_W-1:2],2'b00}.
//   - In ISSUE: instr_valid<=0, instr<=0, go FETCH (branch beats stall).
//   - In FETCH without ack same cycle: addr must stay stable, so discard<=1, PC update deferred
//     until ack; on ack data dropped and fetch restarts at target.
//   - In FETCH with ack same cycle: data dropped, PC<=target, stay FETCH.
//   - In IDLE: PC<=target before first request.
//  Latency: ack at cycle N -> instr_valid=1 at N+1; zero-wait imem sustains 1 instruction / 2 cycles.
//  Arithmetic: PC+4 is modulo 2^ADDR_W (0xFFFF_FFFC -> 0x0000_0000); no overflow flag.
//  Field outputs are pure slices of the instr register (no extra delay); all 0 while instr_valid=0.
//  imem_ack while not in FETCH is ignored.
// TESTING
//  1 reset high, release -> req=1 addr=0x0 next edge; ack rdata=0x012A4020 -> valid=1, op=0, funct=0x20,
//    rs=9, rt=10, rd=8, pc_plus4=0x4.
//  2 stall=1 for 3 cycles in ISSUE -> instr/fields frozen, req=0; stall=0 -> next req addr=0x4.
//  3 branch_taken target=0x0000_0103 in ISSUE with stall=1 -> valid=0, instr=0, next req addr=0x100.
//  4 branch_taken target=0x200 in FETCH, ack 2 cycles later (rdata=0xDEADBEEF) -> addr stays 0x8 until
//    ack, data dropped (valid stays 0), next req addr=0x200.
//  5 RESET_PC=0xFFFF_FFFC, ack, stall=0 -> next req addr=0x0000_0000, pc_plus4=0x0.
//  6 reset asserted mid-FETCH with ack same cycle -> req=0, valid=0, instr=0 immediately; nothing latched.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch channel: the fetch unit drives req/addr and
// memory answers with a one-cycle ack pulse carrying rdata.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  // fetch unit side
  modport master (output req, addr, input ack, rdata);
  // instruction memory side
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: owns the PC, runs the req/ack fetch handshake
// with imem, and presents the registered instruction plus its decoded fields.
// Handles datapath stall and branch redirect, including redirects that land
// while a fetch is still outstanding.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [5:0]          op,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [15:0]         imm,
  output logic [ADDR_W-1:0]   pc_plus4
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  // Word alignment: low two address bits are always zero.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;   // redirect target parked while a fetch is in flight
  logic              discard, discard_nxt;   // in-flight fetch belongs to the wrong path
  logic              accept;                 // ack that delivers a live instruction
  logic              retire;                 // current instruction leaves ISSUE
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign tgt    = branch_target & ALIGN_MASK;
  assign pc_inc = pc + ADDR_W'(4);  // wraps modulo 2^ADDR_W

  // The address must not move while req is up, so a redirect that arrives
  // mid-fetch is parked in pend_pc and applied when the stale ack returns.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    discard_nxt = discard;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
        if (branch_taken) pc_nxt = tgt;
      end
      S_FETCH: begin
        if (imem.ack) begin
          if (discard || branch_taken) begin
            // wrong-path data: drop it and restart at the redirect target
            discard_nxt = 1'b0;
            pc_nxt      = branch_taken ? tgt : pend_pc;
          end else begin
            accept    = 1'b1;
            state_nxt = S_ISSUE;
          end
        end else if (branch_taken) begin
          discard_nxt = 1'b1;
          pend_pc_nxt = tgt;
        end
      end
      S_ISSUE: begin
        // branch beats stall
        if (branch_taken) begin
          pc_nxt    = tgt;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (!stall) begin
          pc_nxt    = pc_inc;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, PC, parked redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= PC_INIT;
      pend_pc <= PC_INIT;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      discard <= discard_nxt;
    end
  end

  // Issue register: captures accepted words, clears to NOP on retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_plus4    <= PC_INIT + ADDR_W'(4);
    end else if (accept) begin
      instr_valid <= 1'b1;
      instr       <= imem.rdata;
      pc_plus4    <= pc_inc;
    end else if (retire) begin
      instr_valid <= 1'b0;
      instr       <= '0;
    end
  end

  assign imem.req  = (state == S_FETCH);
  assign imem.addr = pc;

  // Fields are plain slices; instr is zero when nothing is live.
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios on two instances (reset PC
// of 0 and of the top word), then randomized imem/stall/branch traffic
// checked against a program-order reference model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.ADDR_W(32)) imem0 ();
  instr_fetch_unit_if #(.ADDR_W(32)) imem1 ();

  logic        stall0, br0, stall1, br1;
  logic [31:0] tgt0, tgt1;
  logic        valid0, valid1;
  logic [31:0] instr0, instr1, pp40, pp41;
  logic [5:0]  op0, op1, funct0, funct1;
  logic [4:0]  rs0, rs1, rt0, rt1, rd0, rd1, sh0, sh1;
  logic [15:0] imm0, imm1;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .reset(reset), .imem(imem0), .stall(stall0),
    .branch_taken(br0), .branch_target(tgt0), .instr_valid(valid0),
    .instr(instr0), .op(op0), .rs(rs0), .rt(rt0), .rd(rd0), .shamt(sh0),
    .funct(funct0), .imm(imm0), .pc_plus4(pp40)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .reset(reset), .imem(imem1), .stall(stall1),
    .branch_taken(br1), .branch_target(tgt1), .instr_valid(valid1),
    .instr(instr1), .op(op1), .rs(rs1), .rt(rt1), .rd(rd1), .shamt(sh1),
    .funct(funct1), .imm(imm1), .pc_plus4(pp41)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic        m_valid;
  logic [31:0] m_instr, m_pp4, m_addr, m_next;
  logic        m_drop;
  logic        r_ack, r_stall, r_br;
  logic [31:0] r_rdata, r_tgt;

  initial begin
    reset = 1'b1;
    stall0 = 0; br0 = 0; tgt0 = 0; stall1 = 0; br1 = 0; tgt1 = 0;
    imem0.ack = 0; imem0.rdata = 0; imem1.ack = 0; imem1.rdata = 0;

    // reset state
    #12;
    check("rst_req0",   32'(imem0.req), 32'd0);
    check("rst_addr0",  imem0.addr, 32'h0);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_instr0", instr0, 32'h0);
    check("rst_pp40",   pp40, 32'h4);
    check("rst_addr1",  imem1.addr, 32'hFFFF_FFFC);
    check("rst_pp41",   pp41, 32'h0);
    check("rst_fields1", {op1, rs1, rt1, rd1, sh1, funct1} ^ 32'(imm1), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // first request one edge after reset release
    @(negedge clk);
    check("t1_req0",  32'(imem0.req), 32'd1);
    check("t1_addr0", imem0.addr, 32'h0);
    check("t5_req1",  32'(imem1.req), 32'd1);
    check("t5_addr1", imem1.addr, 32'hFFFF_FFFC);
    imem0.ack = 1; imem0.rdata = 32'h012A_4020; stall0 = 1;
    imem1.ack = 1; imem1.rdata = 32'h2000_0001;
    @(negedge clk);
    imem0.ack = 0; imem1.ack = 0;
    check("t1_valid",  32'(valid0), 32'd1);
    check("t1_instr",  instr0, 32'h012A_4020);
    check("t1_op",     32'(op0), 32'h0);
    check("t1_funct",  32'(funct0), 32'h20);
    check("t1_rs",     32'(rs0), 32'd9);
    check("t1_rt",     32'(rt0), 32'd10);
    check("t1_rd",     32'(rd0), 32'd8);
    check("t1_shamt",  32'(sh0), 32'd0);
    check("t1_imm",    32'(imm0), 32'h4020);
    check("t1_pp4",    pp40, 32'h4);
    check("t1_req",    32'(imem0.req), 32'd0);
    check("t5_valid1", 32'(valid1), 32'd1);
    check("t5_pp41",   pp41, 32'h0);

    // stall holds the issued instruction
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(valid0), 32'd1);
      check("t2_instr", instr0, 32'h012A_4020);
      check("t2_rd",    32'(rd0), 32'd8);
      check("t2_req",   32'(imem0.req), 32'd0);
      if (i == 0) begin
        check("t5_wrap_req",  32'(imem1.req), 32'd1);
        check("t5_wrap_addr", imem1.addr, 32'h0);
        check("t5_wrap_valid", 32'(valid1), 32'd0);
      end
    end
    stall0 = 0;
    @(negedge clk);
    check("t2_req_next",  32'(imem0.req), 32'd1);
    check("t2_addr_next", imem0.addr, 32'h4);
    check("t2_instr_clr", instr0, 32'h0);

    // branch beats stall in ISSUE
    imem0.ack = 1; imem0.rdata = 32'h8C43_0004; stall0 = 1;
    @(negedge clk);
    imem0.ack = 0;
    check("t3_valid_pre", 32'(valid0), 32'd1);
    check("t3_pp4", pp40, 32'h8);
    br0 = 1; tgt0 = 32'h0000_0103;
    @(negedge clk);
    br0 = 0; stall0 = 0;
    check("t3_valid", 32'(valid0), 32'd0);
    check("t3_instr", instr0, 32'h0);
    check("t3_req",   32'(imem0.req), 32'd1);
    check("t3_addr",  imem0.addr, 32'h100);

    // redirect while fetch outstanding
    imem0.ack = 1; imem0.rdata = 32'h0085_1020;
    @(negedge clk);
    imem0.ack = 0;
    check("t4_pp4", pp40, 32'h104);
    @(negedge clk);
    check("t4_addr_a", imem0.addr, 32'h104);
    br0 = 1; tgt0 = 32'h200;
    @(negedge clk);
    br0 = 0;
    check("t4_addr_hold1", imem0.addr, 32'h104);
    @(negedge clk);
    check("t4_addr_hold2", imem0.addr, 32'h104);
    check("t4_req_hold",   32'(imem0.req), 32'd1);
    imem0.ack = 1; imem0.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem0.ack = 0;
    check("t4_valid", 32'(valid0), 32'd0);
    check("t4_instr", instr0, 32'h0);
    check("t4_addr",  imem0.addr, 32'h200);

    // redirect with ack in the same cycle
    imem0.ack = 1; imem0.rdata = 32'h1111_1111; br0 = 1; tgt0 = 32'h300;
    @(negedge clk);
    imem0.ack = 0; br0 = 0;
    check("tb_valid", 32'(valid0), 32'd0);
    check("tb_addr",  imem0.addr, 32'h300);

    // ack outside FETCH is ignored
    imem0.ack = 1; imem0.rdata = 32'h2222_2222; stall0 = 1;
    @(negedge clk);
    check("ti_instr", instr0, 32'h2222_2222);
    check("ti_pp4",   pp40, 32'h304);
    imem0.rdata = 32'h3333_3333;
    @(negedge clk);
    imem0.ack = 0;
    check("ti_instr_hold", instr0, 32'h2222_2222);
    stall0 = 0;
    @(negedge clk);
    check("ti_addr", imem0.addr, 32'h304);

    // reset mid-FETCH with ack in the same cycle
    imem0.ack = 1; imem0.rdata = 32'h4444_4444; reset = 1;
    #1;
    check("t6_req",   32'(imem0.req), 32'd0);
    check("t6_valid", 32'(valid0), 32'd0);
    check("t6_instr", instr0, 32'h0);
    @(negedge clk);
    imem0.ack = 0;
    check("t6_valid_post", 32'(valid0), 32'd0);
    check("t6_instr_post", instr0, 32'h0);
    // redirect during IDLE
    reset = 0; br0 = 1; tgt0 = 32'h41;
    @(negedge clk);
    br0 = 0;
    check("tidle_req",  32'(imem0.req), 32'd1);
    check("tidle_addr", imem0.addr, 32'h40);

    // randomized traffic against the program-order model
    m_valid = 0; m_instr = 0; m_pp4 = 0; m_addr = 32'h40; m_next = 32'h40; m_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_valid", 32'(valid0), 32'(m_valid));
      check("rnd_req",   32'(imem0.req), 32'(!m_valid));
      if (m_valid) begin
        check("rnd_instr", instr0, m_instr);
        check("rnd_pp4",   pp40, m_pp4);
        check("rnd_fields", {op0, rs0, rt0, rd0, sh0, funct0}, m_instr);
      end else begin
        check("rnd_instr0", instr0, 32'h0);
        check("rnd_addr",   imem0.addr, m_addr);
      end
      r_ack   = ($urandom_range(0, 4) < 2);
      r_rdata = $urandom;
      r_stall = $urandom_range(0, 1) == 1;
      r_br    = ($urandom_range(0, 7) == 0);
      r_tgt   = $urandom & 32'h0000_FFFF;
      imem0.ack = r_ack; imem0.rdata = r_rdata;
      stall0 = r_stall; br0 = r_br; tgt0 = r_tgt;
      if (m_valid) begin
        if (r_br) begin
          m_next = r_tgt & 32'hFFFF_FFFC; m_valid = 0; m_instr = 0; m_addr = m_next;
        end else if (!r_stall) begin
          m_next = m_next + 4; m_valid = 0; m_instr = 0; m_addr = m_next;
        end
      end else if (r_ack) begin
        if (m_drop || r_br) begin
          m_drop = 0;
          if (r_br) m_next = r_tgt & 32'hFFFF_FFFC;
          m_addr = m_next;
        end else begin
          m_valid = 1; m_instr = r_rdata; m_pp4 = m_addr + 4;
        end
      end else if (r_br) begin
        m_drop = 1; m_next = r_tgt & 32'hFFFF_FFFC;
      end
      @(negedge clk);
    end
    imem0.ack = 0; br0 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
